mul_div_unit: RTL and testbench

- Execute-stage HI/LO unit.
- Consumes the 4-bit `mulOp` code from the instruction decoder, with operands A=rs and B=rt from the forwarding network.
- Performs MIPS32 MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO. Holds the architectural HI and LO registers.
- Raises `busy` so the pipeline can stall instructions whose decode asserted `mulWait` (MFHI, MFLO, MTHI, MTLO, MUL) until HI/LO are final.

---
 rtl/mul_div_unit.sv | 182 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: execute-stage HI/LO unit for MIPS32 multiply/divide.
// Multi-cycle multiply/accumulate and restoring divide; busy stalls HI/LO readers.
module mul_div_unit #(
   parameter int MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        opValid,
   input  logic [3:0]  mulOp,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic        kill,
   output logic        ready,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV_PRE,
      S_DIV_ITER,
      S_DIV_POST
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        accept;
   logic        is_mthi, is_mtlo, is_mul, is_div;
   logic        sgn;
   logic [63:0] mul_a, mul_b, mul_p, mul_res;
   logic [31:0] abs_a, abs_b;
   logic [32:0] shifted;
   logic [33:0] diff;

   assign ready  = (state_q == S_IDLE);
   assign busy   = ~ready;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign accept = opValid & ready & ~kill;

   assign is_mtlo = (mulOp == 4'b0100);
   assign is_mthi = (mulOp == 4'b0110);
   assign is_mul  = mulOp[3] & (mulOp[2] | ~mulOp[1]);
   assign is_div  = (mulOp[3:1] == 3'b101);

   // op_q[0] set means unsigned; low 64 bits of the product are exact mod 2^64
   assign sgn   = ~op_q[0];
   assign mul_a = {{32{sgn & a_q[31]}}, a_q};
   assign mul_b = {{32{sgn & b_q[31]}}, b_q};
   assign mul_p = mul_a * mul_b;

   always_comb begin
      mul_res = prod_q;
      if (op_q[2]) begin
         if (op_q[1]) mul_res = {hi_q, lo_q} - prod_q;
         else         mul_res = {hi_q, lo_q} + prod_q;
      end
   end

   assign abs_a   = (sgn & a_q[31]) ? -a_q : a_q;
   assign abs_b   = (sgn & b_q[31]) ? -b_q : b_q;
   assign shifted = {rem_q, quo_q[31]};
   assign diff    = {1'b0, shifted} - {2'b00, b_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d = mulOp[2:0];
               a_d  = opA;
               b_d  = opB;
               if (is_mthi) hi_d = opA;
               if (is_mtlo) lo_d = opA;
               if (is_mul) begin
                  state_d = S_MUL;
                  cnt_d   = 6'(MUL_LAT - 1);
               end else if (is_div) begin
                  state_d = S_DIV_PRE;
               end
            end
         end
         S_MUL: begin
            prod_d = mul_p;
            if (cnt_q == '0) begin
               {hi_d, lo_d} = mul_res;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         S_DIV_PRE: begin
            quo_d   = abs_a;
            b_d     = abs_b;
            rem_d   = '0;
            negq_d  = sgn & (a_q[31] ^ b_q[31]);
            negr_d  = sgn & a_q[31];
            cnt_d   = 6'd31;
            state_d = S_DIV_ITER;
         end
         S_DIV_ITER: begin
            quo_d = {quo_q[30:0], ~diff[33]};
            rem_d = diff[33] ? shifted[31:0] : diff[31:0];
            if (cnt_q == '0) state_d = S_DIV_POST;
            else             cnt_d   = cnt_q - 6'd1;
         end
         S_DIV_POST: begin
            // b_q holds |B|, so zero here means the divisor was zero
            if (b_q == '0) begin
               lo_d = 32'hFFFF_FFFF;
               hi_d = a_q;
            end else begin
               lo_d = negq_q ? -quo_q : quo_q;
               hi_d = negr_q ? -rem_q : rem_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (kill) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        opValid;
   logic [3:0]  mulOp;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        kill;
   logic        ready;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [3:0] OP_MTLO  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0110;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_MADDU = 4'b1101;
   localparam logic [3:0] OP_MSUB  = 4'b1110;

   mul_div_unit #(.MUL_LAT(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .opValid(opValid),
      .mulOp  (mulOp),
      .opA    (opA),
      .opB    (opB),
      .kill   (kill),
      .ready  (ready),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // Issue one op, scramble the inputs after accept, count busy samples.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cyc);
      @(negedge clk);
      opValid = 1'b1;
      mulOp   = op;
      opA     = a;
      opB     = b;
      @(negedge clk);
      opValid = 1'b0;
      mulOp   = OP_MULT;
      opA     = ~a;
      opB     = ~b;
      cyc     = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      opValid = 1'b0;
      mulOp   = 4'b0000;
      opA     = '0;
      opB     = '0;
      kill    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (hi !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_hi got %h want %h", hi, 32'h0);
      end
      n_tests++;
      if (lo !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_lo got %h want %h", lo, 32'h0);
      end
      n_tests++;
      if ({busy, ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_busy_ready got %b want 01", {busy, ready});
      end
   endtask

   task automatic test_mthi_mtlo();
      logic saw_busy;
      @(negedge clk);
      opValid = 1'b1;
      mulOp   = OP_MTHI;
      opA     = 32'h1234_5678;
      @(negedge clk);
      saw_busy = busy;
      mulOp    = OP_MTLO;
      opA      = 32'h9ABC_DEF0;
      @(negedge clk);
      saw_busy = saw_busy | busy;
      opValid  = 1'b0;
      opA      = 32'h0;
      @(negedge clk);
      saw_busy = saw_busy | busy;
      n_tests++;
      if (hi !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL mthi got %h want %h", hi, 32'h1234_5678);
      end
      n_tests++;
      if (lo !== 32'h9ABC_DEF0) begin
         n_fail++;
         $display("FAIL mtlo got %h want %h", lo, 32'h9ABC_DEF0);
      end
      n_tests++;
      if (saw_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mt_busy got %b want 0", saw_busy);
      end
   endtask

   task automatic test_mult();
      int cyc;
      run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, cyc);
      n_tests++;
      if (cyc !== 3) begin
         n_fail++;
         $display("FAIL mult_latency got %0d want 3", cyc);
      end
      n_tests++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         n_fail++;
         $display("FAIL mult got %h_%h want ffffffff_fffffffe", hi, lo);
      end
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, cyc);
      n_tests++;
      if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
         n_fail++;
         $display("FAIL multu got %h_%h want 00000001_fffffffe", hi, lo);
      end
   endtask

   task automatic test_madd_msub();
      int cyc;
      run_op(OP_MTHI, 32'h0, 32'h0, cyc);
      run_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, cyc);
      run_op(OP_MADDU, 32'h1, 32'h1, cyc);
      n_tests++;
      if ({hi, lo} !== 64'h0000_0001_0000_0000) begin
         n_fail++;
         $display("FAIL maddu got %h_%h want 00000001_00000000", hi, lo);
      end
      run_op(OP_MSUB, 32'h1, 32'h2, cyc);
      n_tests++;
      if ({hi, lo} !== 64'h0000_0000_FFFF_FFFE) begin
         n_fail++;
         $display("FAIL msub got %h_%h want 00000000_fffffffe", hi, lo);
      end
   endtask

   task automatic test_div();
      int cyc;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, cyc);
      n_tests++;
      if (cyc !== 34) begin
         n_fail++;
         $display("FAIL div_latency got %0d want 34", cyc);
      end
      n_tests++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         n_fail++;
         $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo);
      end
      run_op(OP_DIVU, 32'd100, 32'd7, cyc);
      n_tests++;
      if ({hi, lo} !== {32'd2, 32'd14}) begin
         n_fail++;
         $display("FAIL divu got %h_%h want 00000002_0000000e", hi, lo);
      end
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      n_tests++;
      if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
         n_fail++;
         $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo);
      end
      run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, cyc);
      n_tests++;
      if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin
         n_fail++;
         $display("FAIL div_negb got %h_%h want 00000001_fffffffd", hi, lo);
      end
      run_op(OP_DIV, 32'hFFFF_FFFB, 32'h0, cyc);
      n_tests++;
      if ({hi, lo} !== 64'hFFFF_FFFB_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL div_zero got %h_%h want fffffffb_ffffffff", hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      @(negedge clk);
      opValid = 1'b1;
      mulOp   = OP_DIVU;
      opA     = 32'd5;
      opB     = 32'd0;
      @(negedge clk);
      mulOp = OP_MULT;
      opA   = 32'd3;
      opB   = 32'd4;
      cyc   = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      n_tests++;
      if (cyc !== 34) begin
         n_fail++;
         $display("FAIL divu0_latency got %0d want 34", cyc);
      end
      n_tests++;
      if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL divu0 got %h_%h want 00000005_ffffffff", hi, lo);
      end
      n_tests++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready got %b want 1", ready);
      end
      @(negedge clk);
      opValid = 1'b0;
      cyc     = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      n_tests++;
      if (cyc !== 3) begin
         n_fail++;
         $display("FAIL b2b_mult_latency got %0d want 3", cyc);
      end
      n_tests++;
      if ({hi, lo} !== 64'h0000_0000_0000_000C) begin
         n_fail++;
         $display("FAIL b2b_mult got %h_%h want 00000000_0000000c", hi, lo);
      end
   endtask

   task automatic test_kill();
      int cyc;
      run_op(OP_MTHI, 32'hAA, 32'h0, cyc);
      run_op(OP_MTLO, 32'hBB, 32'h0, cyc);
      @(negedge clk);
      opValid = 1'b1;
      mulOp   = OP_DIV;
      opA     = 32'd100;
      opB     = 32'd3;
      @(negedge clk);
      opValid = 1'b0;
      repeat (9) @(negedge clk);
      n_tests++;
      if ({busy, ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL kill_pre_busy got %b want 10", {busy, ready});
      end
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL kill_busy got %b want 0", busy);
      end
      repeat (40) @(negedge clk);
      n_tests++;
      if ({hi, lo} !== {32'hAA, 32'hBB}) begin
         n_fail++;
         $display("FAIL kill_div got %h_%h want 000000aa_000000bb", hi, lo);
      end
      opValid = 1'b1;
      mulOp   = OP_MTLO;
      opA     = 32'h123;
      kill    = 1'b1;
      @(negedge clk);
      opValid = 1'b0;
      kill    = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({busy, lo} !== {1'b0, 32'hBB}) begin
         n_fail++;
         $display("FAIL kill_mtlo got %h want %h", {busy, lo}, {1'b0, 32'hBB});
      end
      @(negedge clk);
      opValid = 1'b1;
      mulOp   = OP_MULTU;
      opA     = 32'h10;
      opB     = 32'h10;
      @(negedge clk);
      opValid = 1'b0;
      @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if ({busy, hi, lo} !== {1'b0, 32'hAA, 32'hBB}) begin
         n_fail++;
         $display("FAIL kill_mul got %h want %h", {busy, hi, lo},
                  {1'b0, 32'hAA, 32'hBB});
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      opValid = 1'b1;
      mulOp   = OP_DIVU;
      opA     = 32'd50;
      opB     = 32'd5;
      @(negedge clk);
      opValid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, hi, lo} !== {1'b0, 64'h0}) begin
         n_fail++;
         $display("FAIL reset_mid got %h want 0", {busy, hi, lo});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      n_tests++;
      if ({busy, hi, lo} !== {1'b0, 64'h0}) begin
         n_fail++;
         $display("FAIL reset_mid_after got %h want 0", {busy, hi, lo});
      end
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_mult();
      test_madd_msub();
      test_div();
      test_back_to_back();
      test_kill();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
